// File: rtl/act_pkg.sv
// Shared types and constants for the activation scheduler slice.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_TANH   = 2'b10,
    ACT_RSVD   = 2'b11
  } act_func_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam logic [31:0] FP_ZERO      = 32'h00000000;
  localparam logic [31:0] FP_ONE       = 32'h3F800000;
  localparam logic [31:0] FP_MINUS_ONE = 32'hBF800000;

  // The reserved code is served as a bypass so the shared unit never sees it.
  function automatic logic [1:0] remap_func(input logic [1:0] f);
    if (f == 2'(ACT_RSVD)) return 2'(ACT_BYPASS);
    return f;
  endfunction

endpackage

// File: rtl/act_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_valid_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_valid_o = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (!any_valid_o && valid_i[idx]) begin
        any_valid_o  = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/act_scheduler.sv
// Time-shares one combinational activation unit between NUM_REQ requesters,
// holding its inputs for LATENCY cycles so the unit can be a multicycle path.
module act_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ*2-1:0]         req_func,
  output logic [DATA_W-1:0]            act_operand,
  output logic [1:0]                   act_func,
  input  logic [DATA_W-1:0]            act_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic                         busy
);
  import act_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = ($clog2(LATENCY+1) < 1) ? 1 : $clog2(LATENCY+1);

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        func_q, func_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_valid;
  logic [DATA_W-1:0]  grant_data;
  logic [1:0]         grant_func;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_arb (
    .valid_i    (req_valid),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (grant),
    .grant_idx_o(grant_idx),
    .any_valid_o(any_valid)
  );

  assign grant_data = req_data[grant_idx*DATA_W +: DATA_W];
  assign grant_func = remap_func(req_func[grant_idx*2 +: 2]);

  // Any grant issued in IDLE is an immediate handshake since ready mirrors valid.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    cnt_d      = cnt_q;
    operand_d  = operand_q;
    rsp_data_d = rsp_data_q;
    func_d     = func_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          operand_d = grant_data;
          func_d    = grant_func;
          rsp_id_d  = grant_idx;
          rr_ptr_d  = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
          if (grant_func == 2'(ACT_BYPASS)) begin
            rsp_data_d = grant_data;
            state_d    = DONE;
          end else begin
            cnt_d   = CNT_W'(LATENCY-1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d = act_result;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      cnt_q      <= '0;
      operand_q  <= '0;
      rsp_data_q <= '0;
      func_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      cnt_q      <= cnt_d;
      operand_q  <= operand_d;
      rsp_data_q <= rsp_data_d;
      func_q     <= func_d;
    end
  end

  assign req_ready   = (rst_n && state_q == IDLE) ? grant : '0;
  assign act_operand = operand_q;
  assign act_func    = func_q;
  assign rsp_valid   = (state_q == DONE);
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_act_scheduler.sv
// Directed, table-driven bench for act_scheduler with a stubbed activation result.
module tb_act_scheduler;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [7:0]   req_func;
  logic [31:0]  act_operand;
  logic [1:0]   act_func;
  logic [31:0]  act_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic         busy;

  int compareCount = 0;
  int errCount     = 0;
  int cycleCount   = 0;

  act_scheduler #(.NUM_REQ(4), .DATA_W(32), .LATENCY(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_func   (req_func),
    .act_operand(act_operand),
    .act_func   (act_func),
    .act_result (act_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  typedef struct {
    logic [3:0]   validMask;
    logic [127:0] dataAll;
    logic [7:0]   funcAll;
    logic [31:0]  stub;
    logic [3:0]   expGrant;
    int           expId;
    logic [1:0]   expFunc;
    logic [31:0]  expData;
    int           expLat;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid  = v.validMask;
    req_data   = v.dataAll;
    req_func   = v.funcAll;
    act_result = v.stub;
    rsp_ready  = 1'b1;
  endtask

  task automatic waitGrant(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if ((req_ready & req_valid) != 4'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic applyReset();
    req_valid = '0; req_data = '0; req_func = '0; act_result = '0; rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rstOperand", act_operand, 32'h0);
    checkOutput("rstFunc", {30'b0, act_func}, 32'h0);
    checkOutput("rstRspValid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("rstRspData", rsp_data, 32'h0);
    checkOutput("rstRspId", {30'b0, rsp_id}, 32'h0);
    checkOutput("rstBusy", {31'b0, busy}, 32'h0);
    checkOutput("rstReqReady", {28'b0, req_ready}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runVector(input vec_t v);
    bit ok;
    bit seen;
    int lat;
    logic [31:0] expOperand;
    expOperand = v.dataAll[v.expId*32 +: 32];
    @(negedge clk);
    applyStimulus(v);
    waitGrant(20, ok);
    checkOutput("grantSeen", {31'b0, ok}, 32'h1);
    checkOutput("grantMask", {28'b0, req_ready}, {28'b0, v.expGrant});
    @(posedge clk);
    #1;
    req_valid = '0;
    lat = 0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        seen = 1'b1;
      end else begin
        checkOutput("waitFuncHeld", {30'b0, act_func}, {30'b0, v.expFunc});
        checkOutput("waitOperandHeld", act_operand, expOperand);
        checkOutput("waitBusy", {31'b0, busy}, 32'h1);
      end
    end
    checkOutput("rspSeen", {31'b0, seen}, 32'h1);
    checkOutput("rspLatency", lat, v.expLat);
    checkOutput("rspId", {30'b0, rsp_id}, v.expId);
    checkOutput("rspData", rsp_data, v.expData);
    checkOutput("rspFunc", {30'b0, act_func}, {30'b0, v.expFunc});
    checkOutput("rspOperand", act_operand, expOperand);
    @(negedge clk);
    checkOutput("idleAfterRsp", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit   ok;
    int   prevCycle;
    vec_t v;

    vecs[0] = '{4'b0001, {32'h44444444, 32'h33333333, 32'h22222222, 32'h3F800000}, 8'b01_01_01_10,
                32'h3F42F7D6, 4'b0001, 0, 2'b10, 32'h3F42F7D6, 4};
    vecs[1] = '{4'b0100, {32'h44444444, 32'hC0490FDB, 32'h22222222, 32'h11111111}, 8'b10_00_10_10,
                32'h0BADBEEF, 4'b0100, 2, 2'b00, 32'hC0490FDB, 1};
    vecs[2] = '{4'b0100, {32'h44444444, 32'hC0490FDB, 32'h22222222, 32'h11111111}, 8'b01_11_01_01,
                32'h0BADBEEF, 4'b0100, 2, 2'b00, 32'hC0490FDB, 1};
    vecs[3] = '{4'b1000, {32'h40000000, 32'h33333333, 32'h22222222, 32'h11111111}, 8'b01_10_10_10,
                32'h40000000, 4'b1000, 3, 2'b01, 32'h40000000, 4};
    vecs[4] = '{4'b1001, {32'h44444444, 32'h33333333, 32'h22222222, 32'hBF800000}, 8'b10_10_10_01,
                32'h00000000, 4'b0001, 0, 2'b01, 32'h00000000, 4};
    vecs[5] = '{4'b0011, {32'h44444444, 32'h33333333, 32'h3F000000, 32'h11111111}, 8'b00_00_10_00,
                32'h3EEC9A9C, 4'b0010, 1, 2'b10, 32'h3EEC9A9C, 4};
    vecs[6] = '{4'b0011, {32'h44444444, 32'h33333333, 32'h22222222, 32'h12345678}, 8'b01_01_01_00,
                32'h0BADBEEF, 4'b0001, 0, 2'b00, 32'h12345678, 1};

    applyReset();
    for (int i = 0; i < 7; i++) runVector(vecs[i]);

    // Backpressure: pointer is 1, so req2 wins; then req1/req3 wait behind a stalled response.
    @(negedge clk);
    req_valid  = 4'b0100;
    req_data   = {32'h44444444, 32'hCAFEF00D, 32'h22222222, 32'h11111111};
    req_func   = 8'b00_00_00_00;
    act_result = 32'h0BADBEEF;
    rsp_ready  = 1'b0;
    waitGrant(20, ok);
    checkOutput("bpGrant", {28'b0, req_ready}, 32'h4);
    @(posedge clk);
    #1;
    req_valid = 4'b1010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("bpRspValid", {31'b0, rsp_valid}, 32'h1);
      checkOutput("bpRspData", rsp_data, 32'hCAFEF00D);
      checkOutput("bpRspId", {30'b0, rsp_id}, 32'h2);
      checkOutput("bpReqReady", {28'b0, req_ready}, 32'h0);
      checkOutput("bpBusy", {31'b0, busy}, 32'h1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bpIdle", {31'b0, busy}, 32'h0);
    checkOutput("bpNextGrant", {28'b0, req_ready}, 32'h8);
    req_valid = '0;

    // Fairness from a fresh pointer with every requester asking for RELU.
    @(negedge clk);
    applyReset();
    @(negedge clk);
    req_valid  = 4'b1111;
    req_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    req_func   = 8'b01_01_01_01;
    act_result = 32'h3F800000;
    rsp_ready  = 1'b1;
    prevCycle  = 0;
    for (int k = 0; k < 6; k++) begin
      waitGrant(20, ok);
      checkOutput("fairSeen", {31'b0, ok}, 32'h1);
      checkOutput("fairGrant", {28'b0, req_ready}, 32'h1 << (k % 4));
      if (k > 0) checkOutput("fairGap", cycleCount - prevCycle, 5);
      prevCycle = cycleCount;
      @(negedge clk);
    end
    req_valid = '0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    checkOutput("fairDrain", {31'b0, ok}, 32'h1);

    // Reset during the second WAIT cycle drops the in-flight op with no response.
    @(negedge clk);
    req_valid  = 4'b0010;
    req_data   = {32'h44444444, 32'h33333333, 32'h3F800000, 32'h11111111};
    req_func   = 8'b00_00_10_00;
    act_result = 32'h3F42F7D6;
    rsp_ready  = 1'b1;
    waitGrant(20, ok);
    checkOutput("rwGrant", {28'b0, req_ready}, 32'h2);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rwOperand", act_operand, 32'h0);
    checkOutput("rwFunc", {30'b0, act_func}, 32'h0);
    checkOutput("rwBusy", {31'b0, busy}, 32'h0);
    checkOutput("rwRspValid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("rwReqReady", {28'b0, req_ready}, 32'h0);
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("rwNoRsp", {31'b0, rsp_valid}, 32'h0);
    end
    v = '{4'b0010, {32'h44444444, 32'h33333333, 32'h3F800000, 32'h11111111}, 8'b00_00_10_00,
          32'h3F42F7D6, 4'b0010, 1, 2'b10, 32'h3F42F7D6, 4};
    runVector(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
    $finish;
  end

endmodule

// File: doc/act_scheduler.md
Name: act_scheduler

Overview:
- Shares one combinational float32 activation datapath (bypass/ReLU/tanh) between NUM_REQ requesters.
- Arbitrates round-robin and registers the operand and function into the shared unit.
- Holds them for LATENCY cycles so the exp/divide chain is a multicycle path, then captures the result.
- Returns the result on a valid/ready response channel tagged with the requester ID.
- Sits between the systolic array output columns and the single activation unit instance.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 32, operand/result width (IEEE-754 single).
- LATENCY, 3, settle cycles allowed for the shared datapath (>=1).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_data  in  NUM_REQ*DATA_W  packed operands; requester i at bits [i*DATA_W +: DATA_W].
- req_func  in  NUM_REQ*2  packed function codes; requester i at bits [i*2 +: 2].
- act_operand  out  DATA_W  operand to the shared activation unit.
- act_func  out  2  function to the shared unit; never 2'b11.
- act_result  in  DATA_W  combinational result from the shared unit.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  DATA_W  activation result.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester served.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, cnt=0; act_operand, act_func, rsp_valid, rsp_data, rsp_id, busy all 0; req_ready all 0.
- Function codes: 00 BYPASS, 01 RELU, 10 TANH, 11 reserved. Reserved is remapped to BYPASS at grant.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Grant the first valid requester searching from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
  - req_ready[grant] = 1 combinationally in the same cycle. Handshake occurs at that edge.
  - On handshake: latch act_operand=req_data[grant], act_func=remapped func, rsp_id=grant, rr_ptr=(grant+1) mod NUM_REQ.
  - Next state: func BYPASS -> DONE with rsp_data=operand. Otherwise -> WAIT with cnt=LATENCY-1.
  - No valid requester: remain in IDLE; rr_ptr unchanged.
- WAIT:
  - Lasts exactly LATENCY cycles; act_operand and act_func are held stable throughout.
  - When cnt==0: rsp_data<=act_result and go to DONE. Otherwise cnt decrements.
- DONE:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - On rsp_valid&&rsp_ready go to IDLE. No back-to-back grant from DONE.
- Latency from the req handshake edge to rsp_valid: LATENCY+1 cycles for RELU/TANH, 1 cycle for BYPASS.
- Throughput is at best one operation per LATENCY+2 cycles.
- req_ready is 0 in WAIT and DONE. Requesters must not make req_valid depend on req_ready.
- Requesters may drop req_valid at any time before the handshake; the arbiter re-evaluates every IDLE cycle.
- act_operand/act_func keep their last values in IDLE and DONE; they change only at grant.
- Reset mid-operation: in-flight op discarded, no response issued, all registers return to reset values.
- LATENCY=1: a single WAIT cycle. cnt is $clog2(LATENCY+1) bits wide, minimum 1.

Decomposition:
- act_pkg:
  - act_func_t enum: ACT_BYPASS=2'b00, ACT_RELU=2'b01, ACT_TANH=2'b10, ACT_RSVD=2'b11.
  - sched_state_t enum: IDLE, WAIT, DONE.
  - FP constants: FP_ZERO=32'h00000000, FP_ONE=32'h3F800000, FP_MINUS_ONE=32'hBF800000.
- Sub-module rr_arbiter (combinational):
  - Inputs: valid vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_valid.
  - Instantiated once.

Test Plan:
- Single TANH: req0 data=32'h3F800000 func=10, act_result stub=32'h3F42F7D6 -> rsp_valid 4 cycles after handshake, rsp_data=32'h3F42F7D6, rsp_id=0, act_func=10 stable for 3 WAIT cycles.
- Fairness: all 4 req_valid held high, rsp_ready=1, func=RELU -> grant/rsp_id sequence 0,1,2,3,0,1; each grant 5 cycles apart.
- BYPASS and reserved: req2 data=32'hC0490FDB func=00, then func=11 -> each response 1 cycle after handshake, rsp_data=32'hC0490FDB, act_func=00 both times.
- Backpressure: rsp_ready=0 for 10 cycles in DONE with req1,req3 valid -> rsp_valid/rsp_data/rsp_id stable, req_ready=0, busy=1. Release -> IDLE next cycle, then grant to the next index after the served ID.
- Pointer wrap: serve req3 alone, then req0 and req3 both valid -> req0 granted; rr_ptr=1 afterwards.
- Reset mid-WAIT: assert rst_n=0 in the 2nd WAIT cycle -> all outputs 0 immediately (async), state IDLE, no rsp. After release, req1 TANH completes normally with rsp_id=1.
